mips_fetch_unit: RTL

//  Handshaked instruction fetch sequencer for the multicycle MIPS core. It replaces the fixed FETCH1..FETCH4 byte sequence.
//  On fetch_start it reads one 32-bit instruction as 32/BUSW beats over a req/ready memory bus, tolerating wait states.
//  It returns the assembled word plus PC+4, and supports flush and a wait-state timeout.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_fetch_timer.sv | 36 +++
 rtl/mips_fetch_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the multicycle MIPS core.
//   fetch_state_t : states of the handshaked instruction fetch sequencer
//   statetype     : main controller states
//   opcode        : instruction opcode field encodings
//   functcode     : R-type funct field encodings
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } fetch_state_t;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4,
        DECODE, MEMADR, LBRD, LBWR, SBWR,
        RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIWR
    } statetype;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LB    = 6'b100000,
        OP_SB    = 6'b101000
    } opcode;

    typedef enum logic [5:0] {
        F_ADD = 6'b100000,
        F_SUB = 6'b100010,
        F_AND = 6'b100100,
        F_OR  = 6'b100101,
        F_SLT = 6'b101010
    } functcode;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/mips_fetch_timer.sv
// mips_fetch_timer: per-beat wait-state counter.
//   clk : core clock          rst : async active-low reset
//   clr : zero the count      en  : count one wait cycle (clr has priority)
//   tc  : count has reached TIMEOUT-1 (the next wait cycle is one too many)
module mips_fetch_timer
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + TIMER_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: handshaked instruction fetch sequencer.
// Reads one 32-bit instruction as 32/BUSW little-endian beats over a
// req/ready bus, then presents the word and PC+4 with a one-cycle valid pulse.
//   clk, rst (async active-low)
//   fetch_start, flush, pc_in          : controller side requests
//   mem_req, mem_adr, mem_rdata, mem_ready : memory bus
//   instr, instr_valid, pc_next        : completed fetch result
//   busy, fetch_err                    : status (fetch_err pulses on timeout)
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned BUSW    = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [AWIDTH-1:0] pc_in,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_adr,
    input  logic [BUSW-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [AWIDTH-1:0] pc_next,
    output logic              busy,
    output logic              fetch_err
);

    if (!(BUSW == 8 || BUSW == 16 || BUSW == 32)) begin : g_bad_busw
        $error("mips_fetch_unit: BUSW must be 8, 16 or 32");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mips_fetch_unit: TIMEOUT must be in 1..255");
    end

    localparam int unsigned       BEATS     = INSTR_W / BUSW;
    localparam logic [1:0]        LAST_BEAT = 2'(BEATS - 1);
    localparam logic [AWIDTH-1:0] ADR_STEP  = AWIDTH'(BUSW / 8);
    localparam logic [AWIDTH-1:0] ADR_FOUR  = AWIDTH'(4);

    fetch_state_t        state_q, state_d;
    logic [AWIDTH-1:0]   base_q, base_d;
    logic [AWIDTH-1:0]   adr_q, adr_d;
    logic [AWIDTH-1:0]   pcn_q, pcn_d;
    logic [1:0]          beat_q, beat_d;
    logic [INSTR_W-1:0]  shadow_q, shadow_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                t_clr, t_en, t_tc;

    mips_fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (t_clr),
        .en  (t_en),
        .tc  (t_tc)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        adr_d    = adr_q;
        pcn_d    = pcn_q;
        beat_d   = beat_q;
        shadow_d = shadow_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        // The wait counter only runs across consecutive not-ready REQ cycles;
        // every other path (start, beat accepted, abort, flush) zeroes it.
        t_clr    = 1'b1;
        t_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_start && !flush) begin
                    state_d = REQ;
                    base_d  = pc_in;
                    adr_d   = pc_in;
                    beat_d  = '0;
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    // ready beats a coincident terminal count
                    shadow_d[beat_q*BUSW +: BUSW] = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        adr_d  = adr_q + ADR_STEP;
                    end
                end else if (t_tc) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    t_clr = 1'b0;
                    t_en  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    instr_d = shadow_q;
                    pcn_d   = base_q + ADR_FOUR;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pad-facing status flops are loaded from the next state so they
        // line up with state_q without a decode after the register.
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            adr_q    <= '0;
            pcn_q    <= '0;
            beat_q   <= '0;
            shadow_q <= '0;
            instr_q  <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            adr_q    <= adr_d;
            pcn_q    <= pcn_d;
            beat_q   <= beat_d;
            shadow_q <= shadow_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_adr     = adr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_next     = pcn_q;
    assign busy        = busy_q;
    assign fetch_err   = err_q;

endmodule
